// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-requester OTTER bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } requester_e;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Wide enough for MEM_LATENCY up to 15.
  localparam int CNT_W = 4;

  // Access parameters captured at grant time and replayed onto the bus.
  typedef struct packed {
    requester_e  id;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } access_t;

  // Converts a one-hot grant {ls, if} into a requester id.
  function automatic requester_e grant_to_id(input logic [1:0] grant);
    return grant[1] ? REQ_LS : REQ_IF;
  endfunction

endpackage

// File: rtl/otter_bus.sv
// Single-port OTTER memory bus between an initiator and the address-decoding bus matrix.
interface otter_bus;
  logic        rd;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        error;

  modport primary (
    output rd, wr, size, addr, wdata,
    input  rdata, error
  );

  modport secondary (
    input  rd, wr, size, addr, wdata,
    output rdata, error
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin selector; on a tie the requester that did not win last time is chosen.
module rr_arbiter2
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  requester_e last_grant,
  output logic [1:0] grant
);

  // req[0] is fetch, req[1] is load/store; grant uses the same bit order.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == REQ_IF) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serialises fetch and load/store accesses onto one otter_bus port with round-robin fairness
// and a fixed MEM_LATENCY-cycle bus hold per access.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_error,

  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  output logic [31:0] ls_rdata,
  output logic        ls_error,

  otter_bus.primary   mem_bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  requester_e       last_q, last_d;
  access_t          acc_q, acc_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             error_q, error_d;

  logic [1:0]       grant;
  requester_e       winner;

  logic             bus_rd;
  logic             bus_wr;
  logic [1:0]       bus_size;
  logic [31:0]      bus_addr;
  logic [31:0]      bus_wdata;

  rr_arbiter2 u_rr (
    .req        ({ls_req, if_req}),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign winner = grant_to_id(grant);

  // The bus is decoded from state alone, so an asynchronous reset idles it without a clock edge.
  assign mem_bus.rd    = bus_rd;
  assign mem_bus.wr    = bus_wr;
  assign mem_bus.size  = bus_size;
  assign mem_bus.addr  = bus_addr;
  assign mem_bus.wdata = bus_wdata;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    acc_d     = acc_q;
    rdata_d   = rdata_q;
    error_d   = error_q;

    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_size  = '0;
    bus_addr  = '0;
    bus_wdata = '0;

    if_ack    = 1'b0;
    if_rdata  = '0;
    if_error  = 1'b0;
    ls_ack    = 1'b0;
    ls_rdata  = '0;
    ls_error  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d  = ACCESS;
          cnt_d    = '0;
          last_d   = winner;
          acc_d.id = winner;
          if (winner == REQ_IF) begin
            acc_d.wr    = 1'b0;
            acc_d.size  = SIZE_WORD;
            acc_d.addr  = if_addr;
            acc_d.wdata = '0;
          end else begin
            acc_d.wr    = ls_wr;
            acc_d.size  = ls_size;
            acc_d.addr  = ls_addr;
            acc_d.wdata = ls_wdata;
          end
        end
      end

      ACCESS: begin
        // A fetch was latched with wr=0, so rd=!wr covers both requesters.
        bus_rd    = ~acc_q.wr;
        bus_wr    = acc_q.wr;
        bus_size  = acc_q.size;
        bus_addr  = acc_q.addr;
        bus_wdata = acc_q.wdata;
        if (cnt_q == LAST_CNT) begin
          rdata_d = mem_bus.rdata;
          error_d = mem_bus.error;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
        if (acc_q.id == REQ_IF) begin
          if_ack   = 1'b1;
          if_rdata = rdata_q;
          if_error = error_q;
        end else begin
          ls_ack   = 1'b1;
          ls_rdata = rdata_q;
          ls_error = error_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= REQ_LS;
      acc_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised self-checking bench for bus_arbiter: a transaction-level model predicts every bus
// and response value from grant cycle arithmetic; directed phases cover tie, fairness and reset.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int LAT = 3;
  localparam int M_QUIET = 0;
  localparam int M_RAND  = 1;
  localparam int M_BOTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req, ls_req, ls_wr;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [1:0]  ls_size;
  logic        if_ack, if_error, ls_ack, ls_error;
  logic [31:0] if_rdata, ls_rdata;

  always #5 clk = ~clk;

  otter_bus bus ();

  bus_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .if_error (if_error),
    .ls_req   (ls_req),
    .ls_wr    (ls_wr),
    .ls_size  (ls_size),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_ack   (ls_ack),
    .ls_rdata (ls_rdata),
    .ls_error (ls_error),
    .mem_bus  (bus)
  );

  // Memory response varies with the cycle number, so capturing on the wrong cycle shows up.
  int cyc;

  function automatic logic [31:0] mem_data(input logic [31:0] a, input int c);
    return (a * 32'h9E37_79B1) ^ 32'(c);
  endfunction

  function automatic logic mem_err(input logic [31:0] a, input int c);
    return (a[4:2] == 3'd5) ^ ((c % 4) == 1);
  endfunction

  assign bus.rdata = mem_data(bus.addr, cyc);
  assign bus.error = mem_err(bus.addr, cyc);

  typedef struct {
    bit          valid;
    int          start;
    requester_e  id;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    requester_e id;
    int         at;
  } ack_t;

  txn_t       cur;
  requester_e m_last;
  bit         pend_if, pend_ls;
  ack_t       ack_log[$];
  int         err_acks, ok_acks;
  int         passed, total;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    else
      passed++;
  endtask

  task automatic model_reset();
    cur.valid = 1'b0;
    m_last    = REQ_LS;
    pend_if   = 1'b0;
    pend_ls   = 1'b0;
    if_req    = 1'b0;
    ls_req    = 1'b0;
  endtask

  task automatic drive(input int mode);
    bit if_granted, ls_granted;
    if_granted = cur.valid && cur.id == REQ_IF;
    ls_granted = cur.valid && cur.id == REQ_LS;

    if (!pend_if) begin
      if (mode == M_BOTH || (mode == M_RAND && $urandom_range(2) == 0)) begin
        pend_if = 1'b1;
        if_req  = 1'b1;
        if_addr = $urandom;
      end else begin
        if_req = 1'b0;
      end
    end else if (if_granted) begin
      if_addr = $urandom;
      if (mode == M_RAND && $urandom_range(7) == 0) if_req = 1'b0;
    end

    if (!pend_ls) begin
      if (mode == M_BOTH || (mode == M_RAND && $urandom_range(2) == 0)) begin
        pend_ls  = 1'b1;
        ls_req   = 1'b1;
        ls_wr    = 1'($urandom_range(1));
        ls_size  = 2'($urandom_range(3));
        ls_addr  = $urandom;
        ls_wdata = $urandom;
      end else begin
        ls_req = 1'b0;
      end
    end else if (ls_granted) begin
      ls_wr    = 1'($urandom_range(1));
      ls_addr  = $urandom;
      ls_wdata = $urandom;
      if (mode == M_RAND && $urandom_range(7) == 0) ls_req = 1'b0;
    end
  endtask

  // One cycle, called just after a falling edge: check, then drive, then predict the grant.
  task automatic step(input int mode);
    logic [67:0] eb;
    logic [33:0] ei, el;
    logic [31:0] ed;
    logic        ee;
    bit          busy;
    requester_e  w;

    cyc++;
    eb = '0;
    ei = '0;
    el = '0;
    if (cur.valid && cyc >= cur.start + 1 && cyc <= cur.start + LAT)
      eb = {~cur.wr, cur.wr, cur.size, cur.addr, cur.wdata};
    if (cur.valid && cyc == cur.start + LAT + 1) begin
      ed = mem_data(cur.addr, cur.start + LAT);
      ee = mem_err(cur.addr, cur.start + LAT);
      if (cur.id == REQ_IF) ei = {1'b1, ee, ed};
      else                  el = {1'b1, ee, ed};
    end

    check("bus", {bus.rd, bus.wr, bus.size, bus.addr, bus.wdata}, eb);
    check("if_rsp", {if_ack, if_error, if_rdata}, ei);
    check("ls_rsp", {ls_ack, ls_error, ls_rdata}, el);

    if (if_ack) ack_log.push_back('{REQ_IF, cyc});
    if (ls_ack) ack_log.push_back('{REQ_LS, cyc});
    if (if_ack || ls_ack) begin
      if (if_error || ls_error) err_acks++;
      else                      ok_acks++;
    end

    busy = cur.valid;
    if (cur.valid && cyc == cur.start + LAT + 1) begin
      if (cur.id == REQ_IF) pend_if = 1'b0;
      else                  pend_ls = 1'b0;
      cur.valid = 1'b0;
    end

    drive(mode);

    if (!busy && (if_req || ls_req)) begin
      if (if_req && ls_req) w = (m_last == REQ_IF) ? REQ_LS : REQ_IF;
      else if (if_req)      w = REQ_IF;
      else                  w = REQ_LS;
      m_last    = w;
      cur.valid = 1'b1;
      cur.start = cyc;
      cur.id    = w;
      if (w == REQ_IF) begin
        cur.wr    = 1'b0;
        cur.size  = SIZE_WORD;
        cur.addr  = if_addr;
        cur.wdata = '0;
      end else begin
        cur.wr    = ls_wr;
        cur.size  = ls_size;
        cur.addr  = ls_addr;
        cur.wdata = ls_wdata;
      end
    end
  endtask

  task automatic run(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step(mode);
    end
  endtask

  task automatic preset_tie();
    if_req   = 1'b1;
    if_addr  = 32'h0000_0104;
    pend_if  = 1'b1;
    ls_req   = 1'b1;
    ls_wr    = 1'b1;
    ls_size  = SIZE_WORD;
    ls_addr  = 32'h0000_2000;
    ls_wdata = 32'h1234_5678;
    pend_ls  = 1'b1;
  endtask

  initial begin
    bit found;
    passed   = 0;
    total    = 0;
    cyc      = 0;
    err_acks = 0;
    ok_acks  = 0;
    if_addr  = '0;
    ls_wr    = 1'b0;
    ls_size  = '0;
    ls_addr  = '0;
    ls_wdata = '0;
    model_reset();

    #1;
    check("reset_bus", {bus.rd, bus.wr, bus.size, bus.addr, bus.wdata}, '0);
    check("reset_rsp", {if_ack, if_error, if_rdata, ls_ack, ls_error, ls_rdata}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch from 0x100.
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    pend_if = 1'b1;
    step(M_QUIET);
    run(M_QUIET, LAT + 3);

    // Both requesters held high: grants alternate every LAT+2 cycles.
    ack_log.delete();
    run(M_BOTH, 6 * (LAT + 2));
    check("alt_count", ack_log.size() >= 5, 1'b1);
    for (int i = 1; i < ack_log.size(); i++) begin
      check("alt_id", ack_log[i].id, (ack_log[i-1].id == REQ_IF) ? REQ_LS : REQ_IF);
      check("alt_gap", ack_log[i].at - ack_log[i-1].at, LAT + 2);
    end
    run(M_QUIET, 2 * (LAT + 2) + 2);

    // Random traffic with drops and input changes during access.
    run(M_RAND, 400);
    run(M_QUIET, 2 * (LAT + 2) + 2);
    check("err_seen", err_acks > 0, 1'b1);
    check("ok_seen", ok_acks > 0, 1'b1);

    // Asynchronous reset in the middle of an access.
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      step(M_RAND);
      if (cur.valid && cyc >= cur.start + 1 && cyc <= cur.start + LAT - 1) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_access", found, 1'b1);
    #2;
    check("rst_pre", bus.rd | bus.wr, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async", {bus.rd, bus.wr, if_ack, ls_ack}, '0);
    model_reset();
    @(negedge clk);
    check("rst_hold", {bus.rd, bus.wr, if_ack, ls_ack}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // First tie after reset goes to fetch, then the store.
    ack_log.delete();
    preset_tie();
    step(M_QUIET);
    run(M_QUIET, 2 * (LAT + 2) + 2);
    check("tie_acks", ack_log.size(), 2);
    if (ack_log.size() >= 2) begin
      check("tie_first", ack_log[0].id, REQ_IF);
      check("tie_second", ack_log[1].id, REQ_LS);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-requester arbiter that shares the single `otter_bus` memory port between the instruction-fetch unit and the load/store unit of the multicycle OTTER core. It sits between the core's two access sources and the address-decoding bus matrix, serialising accesses with round-robin fairness. Each access is held on the downstream bus for a fixed, parameterised number of cycles. The response is returned to the granted requester with a one-cycle acknowledge.

## Interface
Parameters:
- `MEM_LATENCY`, 1: cycles `rd`/`wr` stay asserted downstream; `rdata`/`error` are sampled on the last of them. Legal range is 1..15.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  32  fetch address; read-only, size fixed to word (2'b10).
- `if_ack`  out  1  one-cycle pulse; fetch complete.
- `if_rdata`  out  32  fetch data; valid while `if_ack` is high.
- `if_error`  out  1  bus error; valid while `if_ack` is high.
- `ls_req`  in  1  load/store request; held until `ls_ack`.
- `ls_wr`  in  1  1 means store, 0 means load.
- `ls_size`  in  2  access size, passed to `mem_bus.size`.
- `ls_addr`  in  32  access address.
- `ls_wdata`  in  32  store data.
- `ls_ack`, `ls_rdata`, `ls_error`: same widths and meaning as the `if_` outputs.
- `mem_bus`  `otter_bus.primary`  —  downstream port into the bus matrix.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If any `*_req` is high, select a winner.
  - If only one requester is asserting, it wins.
  - If both are asserting, the requester that is not `last_grant` wins.
  - Latch the winner's id, `wr`, `size`, `addr` and `wdata` into registers.
  - Load the counter with 0 and go to ACCESS.
  - Set `last_grant` to the winner.
- ACCESS:
  - Drive `mem_bus` only from the latched registers; the requester inputs are don't-care after the grant.
  - Fetch drives `rd=1, wr=0, size=2'b10, wdata=0`.
  - Load/store drives `rd=!wr` and `wr=wr`.
  - When counter == `MEM_LATENCY-1`, capture `mem_bus.rdata` and `mem_bus.error` into response registers and go to RESP. Otherwise increment the counter.
- RESP:
  - Drive `mem_bus` idle.
  - Assert the granted requester's `*_ack` together with its `*_rdata` and `*_error`.
  - Return to IDLE unconditionally.
- Idle `mem_bus` means `rd=wr=0` and `size=addr=wdata=0`. It is driven idle in IDLE and RESP.
- Non-granted requester outputs are `ack=0`, `rdata=0`, `error=0`.
- A requester that drops `req` mid-access does not abort it. The access runs to completion and the ack still pulses; the requester ignores it.
- A bus error does not retry and does not alter sequencing. It is only reported.
- Reset values:
  - State IDLE, counter 0, `last_grant` = LS (so fetch wins the first tie).
  - All response registers are 0, and all outputs are 0.
- Reset mid-operation: the bus deasserts immediately and asynchronously, and no ack is issued for the interrupted access.

## Timing
- A request seen high in IDLE at cycle 0 is on `mem_bus` in cycles 1..`MEM_LATENCY`, and its ack comes in cycle `MEM_LATENCY+1`.
- Minimum occupancy is `MEM_LATENCY+2` cycles per access, because IDLE is always visited between accesses.
- A requester whose `req` is still high in its ack cycle is treated as a new request in the following IDLE cycle.
- With both requesters continuously asserting, grants strictly alternate.
- `rdata`/`error` are registered; there is no combinational path from `mem_bus` to requester outputs.
- Requester inputs reach `mem_bus` only through registers.

## Structure
- `bus_arbiter_pkg` holds the following:
  - `arb_state_e` (IDLE/ACCESS/RESP).
  - `requester_e` (REQ_IF=0, REQ_LS=1).
  - `SIZE_WORD = 2'b10`.
- The single sub-module is `rr_arbiter2`, a two-input round-robin selector. It takes `req[1:0]` and `last_grant` and returns a one-hot grant; it is purely combinational. The state register, counter and request/response latches live in `bus_arbiter`.

## Test plan
- **Single fetch.** `MEM_LATENCY=1`, memory returns `0xDEADBEEF` for `0x100`. Pulse `if_req` with `if_addr=0x100` → `mem_bus.rd=1, addr=0x100, size=2'b10` in cycle 1. `if_ack=1, if_rdata=0xDEADBEEF` in cycle 2. `ls_ack` stays 0.
- **Tie after reset.** Both `if_req` and `ls_req` rise in the first cycle after reset → fetch served first, then the store (`ls_wr=1, ls_wdata=0x12345678, addr=0x2000`). The second access shows `mem_bus.wr=1` and `wdata=0x12345678`.
- **Fairness.** Both requests are held high for 12 cycles with `MEM_LATENCY=2` → acks alternate IF, LS, IF. Each ack is 4 cycles apart.
- **Latency and error.** `MEM_LATENCY=3`, memory asserts `error=1` on the third access cycle → `rd` is high for exactly 3 cycles. `ls_ack=1` and `ls_error=1` in cycle 4, and the next request is accepted normally.
- **Input change and mid-access reset.** Change `ls_addr` during ACCESS → `mem_bus.addr` is unchanged. Assert `rst_n=0` mid-ACCESS → `mem_bus.rd/wr` go to 0 without a clock edge, no ack is issued, and after release the first tie goes to fetch.
